// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the control pipeline: control-bundle bit positions,
// bundle widths, the packed ID/EX control record and forward-select encodings.
package ctrl_pipeline_pkg;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  // EX bundle: {RegDst, ALUOp[1:0], ALUSrc}
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_HI  = 2;
  localparam int EX_ALUOP_LO  = 1;
  localparam int EX_ALUSRC    = 0;
  // M bundle: {Branch, MemRead, MemWrite}
  localparam int M_BRANCH     = 2;
  localparam int M_MEMREAD    = 1;
  localparam int M_MEMWRITE   = 0;
  // WB bundle: {RegWrite, MemtoReg}
  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

endpackage

// File: rtl/ctrl_pipeline_forwarding_unit.sv
// Combinational EX-stage operand forwarding selects; the younger EX/MEM
// producer wins over MEM/WB, and register 0 never forwards.
module ctrl_pipeline_forwarding_unit
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  exmem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] exmem_dst_i,
  input  logic                  memwb_regwrite_i,
  input  logic [REG_ADDR_W-1:0] memwb_dst_i,
  input  logic [REG_ADDR_W-1:0] idex_rs_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o
);

  function automatic fwd_sel_e select_src(input logic [REG_ADDR_W-1:0] src);
    if (exmem_regwrite_i && (exmem_dst_i != '0) && (exmem_dst_i == src)) begin
      return FWD_EXMEM;
    end else if (memwb_regwrite_i && (memwb_dst_i != '0) && (memwb_dst_i == src)) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

  assign fwd_a_o = select_src(idex_rs_i);
  assign fwd_b_o = select_src(idex_rt_i);

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control pipeline with load-use stall and forwarding.
// Define CTRL_PIPE_PERF_EN to add saturating stall_cnt / flush_cnt outputs.
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef CTRL_PIPE_PERF_EN
  ,
  parameter int PERF_W     = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EX_W-1:0]       EX,
  input  logic [M_W-1:0]        M,
  input  logic [WB_W-1:0]       WB,
  input  logic                  ID_flush,
  input  logic                  EX_flush,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic [EX_W-1:0]       idex_EX,
  output logic [M_W-1:0]        idex_M,
  output logic [WB_W-1:0]       idex_WB,
  output logic [REG_ADDR_W-1:0] idex_rs,
  output logic [REG_ADDR_W-1:0] idex_rt,
  output logic [M_W-1:0]        exmem_M,
  output logic [WB_W-1:0]       exmem_WB,
  output logic [REG_ADDR_W-1:0] exmem_dst,
  output logic [WB_W-1:0]       memwb_WB,
  output logic [REG_ADDR_W-1:0] memwb_dst,
  output logic                  stall,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
`endif
);

  ctrl_t                 idex_ctrl_q, idex_ctrl_d;
  logic [REG_ADDR_W-1:0] idex_rs_q, idex_rs_d;
  logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
  logic [REG_ADDR_W-1:0] idex_rd_q, idex_rd_d;
  logic [M_W-1:0]        exmem_m_q, exmem_m_d;
  logic [WB_W-1:0]       exmem_wb_q, exmem_wb_d;
  logic [REG_ADDR_W-1:0] exmem_dst_q, exmem_dst_d;
  logic [WB_W-1:0]       memwb_wb_q, memwb_wb_d;
  logic [REG_ADDR_W-1:0] memwb_dst_q, memwb_dst_d;
  logic                  load_use;

  // A load in EX whose target is read by the instruction in ID; a flushed ID
  // slot is discarded anyway, so it must not hold the front end.
  assign load_use = idex_ctrl_q.m[M_MEMREAD] && (idex_rt_q != '0) &&
                    ((idex_rt_q == id_rs) || (idex_rt_q == id_rt));
  assign stall    = load_use && !ID_flush;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    idex_ctrl_d = '{ex: EX, m: M, wb: WB};
    idex_rs_d   = id_rs;
    idex_rt_d   = id_rt;
    idex_rd_d   = id_rd;
    if (ID_flush) begin
      idex_ctrl_d = '0;
      idex_rs_d   = '0;
      idex_rt_d   = '0;
      idex_rd_d   = '0;
    end else if (stall) begin
      idex_ctrl_d = '0;
    end

    exmem_m_d   = idex_ctrl_q.m;
    exmem_wb_d  = idex_ctrl_q.wb;
    exmem_dst_d = idex_ctrl_q.ex[EX_REGDST] ? idex_rd_q : idex_rt_q;
    if (EX_flush) begin
      exmem_m_d   = '0;
      exmem_wb_d  = '0;
      exmem_dst_d = '0;
    end

    memwb_wb_d  = exmem_wb_q;
    memwb_dst_d = exmem_dst_q;
  end

  // NOTE: state registers use non-blocking assignments and clear asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl_q <= '0;
      idex_rs_q   <= '0;
      idex_rt_q   <= '0;
      idex_rd_q   <= '0;
      exmem_m_q   <= '0;
      exmem_wb_q  <= '0;
      exmem_dst_q <= '0;
      memwb_wb_q  <= '0;
      memwb_dst_q <= '0;
    end else begin
      idex_ctrl_q <= idex_ctrl_d;
      idex_rs_q   <= idex_rs_d;
      idex_rt_q   <= idex_rt_d;
      idex_rd_q   <= idex_rd_d;
      exmem_m_q   <= exmem_m_d;
      exmem_wb_q  <= exmem_wb_d;
      exmem_dst_q <= exmem_dst_d;
      memwb_wb_q  <= memwb_wb_d;
      memwb_dst_q <= memwb_dst_d;
    end
  end

  assign idex_EX   = idex_ctrl_q.ex;
  assign idex_M    = idex_ctrl_q.m;
  assign idex_WB   = idex_ctrl_q.wb;
  assign idex_rs   = idex_rs_q;
  assign idex_rt   = idex_rt_q;
  assign exmem_M   = exmem_m_q;
  assign exmem_WB  = exmem_wb_q;
  assign exmem_dst = exmem_dst_q;
  assign memwb_WB  = memwb_wb_q;
  assign memwb_dst = memwb_dst_q;

  ctrl_pipeline_forwarding_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_forwarding_unit (
    .exmem_regwrite_i (exmem_wb_q[WB_REGWRITE]),
    .exmem_dst_i      (exmem_dst_q),
    .memwb_regwrite_i (memwb_wb_q[WB_REGWRITE]),
    .memwb_dst_i      (memwb_dst_q),
    .idex_rs_i        (idex_rs_q),
    .idex_rt_i        (idex_rt_q),
    .fwd_a_o          (ForwardA),
    .fwd_b_o          (ForwardB)
  );

`ifdef CTRL_PIPE_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if ((ID_flush || EX_flush) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: the driver pushes a hand-computed
// expected snapshot per cycle, a monitor pops and compares on the falling edge.
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ex_i;
  logic [2:0] m_i;
  logic [1:0] wb_i;
  logic       id_flush, ex_flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [3:0] idex_ex;
  logic [2:0] idex_m, exmem_m;
  logic [1:0] idex_wb, exmem_wb, memwb_wb;
  logic [4:0] idex_rs, idex_rt, exmem_dst, memwb_dst;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;
`ifdef CTRL_PIPE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string      name;
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rs, rt;
    logic [2:0] xm;
    logic [1:0] xwb;
    logic [4:0] xdst;
    logic [1:0] wwb;
    logic [4:0] wdst;
    logic       st;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .EX        (ex_i),
    .M         (m_i),
    .WB        (wb_i),
    .ID_flush  (id_flush),
    .EX_flush  (ex_flush),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .idex_EX   (idex_ex),
    .idex_M    (idex_m),
    .idex_WB   (idex_wb),
    .idex_rs   (idex_rs),
    .idex_rt   (idex_rt),
    .exmem_M   (exmem_m),
    .exmem_WB  (exmem_wb),
    .exmem_dst (exmem_dst),
    .memwb_WB  (memwb_wb),
    .memwb_dst (memwb_dst),
    .stall     (stall),
    .ForwardA  (fwd_a),
    .ForwardB  (fwd_b)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".idex_EX"},   32'(idex_ex),   32'(e.ex));
        check({e.name, ".idex_M"},    32'(idex_m),    32'(e.m));
        check({e.name, ".idex_WB"},   32'(idex_wb),   32'(e.wb));
        check({e.name, ".idex_rs"},   32'(idex_rs),   32'(e.rs));
        check({e.name, ".idex_rt"},   32'(idex_rt),   32'(e.rt));
        check({e.name, ".exmem_M"},   32'(exmem_m),   32'(e.xm));
        check({e.name, ".exmem_WB"},  32'(exmem_wb),  32'(e.xwb));
        check({e.name, ".exmem_dst"}, 32'(exmem_dst), 32'(e.xdst));
        check({e.name, ".memwb_WB"},  32'(memwb_wb),  32'(e.wwb));
        check({e.name, ".memwb_dst"}, 32'(memwb_dst), 32'(e.wdst));
        check({e.name, ".stall"},     32'(stall),     32'(e.st));
        check({e.name, ".ForwardA"},  32'(fwd_a),     32'(e.fa));
        check({e.name, ".ForwardB"},  32'(fwd_b),     32'(e.fb));
      end
    end
  end

  // Apply one cycle of inputs just after the edge and queue what the outputs
  // must show during that cycle.
  task automatic step(
    input string name, input logic r,
    input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
    input logic idf, input logic exf,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic [3:0] e_ex, input logic [2:0] e_m, input logic [1:0] e_wb,
    input logic [4:0] e_rs, input logic [4:0] e_rt,
    input logic [2:0] x_m, input logic [1:0] x_wb, input logic [4:0] x_dst,
    input logic [1:0] w_wb, input logic [4:0] w_dst,
    input logic e_st, input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_i = ex; m_i = m; wb_i = wb; id_flush = idf; ex_flush = exf;
    id_rs = rs; id_rt = rt; id_rd = rd;
    e = '{name: name, ex: e_ex, m: e_m, wb: e_wb, rs: e_rs, rt: e_rt,
          xm: x_m, xwb: x_wb, xdst: x_dst, wwb: w_wb, wdst: w_dst,
          st: e_st, fa: e_fa, fb: e_fb};
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_i = '0; m_i = '0; wb_i = '0; id_flush = 1'b0; ex_flush = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //    name            rst EX       M       WB     idf exf rs  rt  rd  | idex EX/M/WB/rs/rt          | exmem M/WB/dst     | memwb WB/dst | st fa     fb
    step("reset_state",   0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    // R-type writing r3 travels through all three stages.
    step("rtype_in",      0, 4'b1100, 3'b000, 2'b10, 0, 0, 1,  2,  3,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    step("rtype_idex",    0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b1100, 3'b000, 2'b10, 1,  2,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    step("rtype_exmem",   0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b10, 3,  2'b00, 0,  0, 2'b00, 2'b00);
    step("rtype_memwb",   0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b10, 3,  0, 2'b00, 2'b00);
    // LW r4 followed by a consumer of r4: one stall, then a bubble.
    step("lw_in",         0, 4'b0001, 3'b010, 2'b11, 0, 0, 1,  4,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    step("lu_stall",      0, 4'b1100, 3'b000, 2'b10, 0, 0, 4,  6,  7,  4'b0001, 3'b010, 2'b11, 1,  4,  3'b000, 2'b00, 0,  2'b00, 0,  1, 2'b00, 2'b00);
    step("lu_bubble",     0, 4'b1100, 3'b000, 2'b10, 0, 0, 4,  6,  7,  4'b0000, 3'b000, 2'b00, 4,  6,  3'b010, 2'b11, 4,  2'b00, 0,  0, 2'b10, 2'b00);
    step("lu_resume",     0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b1100, 3'b000, 2'b10, 4,  6,  3'b000, 2'b00, 6,  2'b11, 4,  0, 2'b01, 2'b00);
    // Back-to-back producers of r5, then a consumer of r5 on both operands.
    step("r5_first",      0, 4'b1100, 3'b000, 2'b10, 0, 0, 1,  2,  5,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b10, 7,  2'b00, 6,  0, 2'b00, 2'b00);
    step("r5_second",     0, 4'b1100, 3'b000, 2'b10, 0, 0, 1,  2,  5,  4'b1100, 3'b000, 2'b10, 1,  2,  3'b000, 2'b00, 0,  2'b10, 7,  0, 2'b00, 2'b00);
    step("r5_consumer",   0, 4'b1100, 3'b000, 2'b10, 0, 0, 5,  5,  8,  4'b1100, 3'b000, 2'b10, 1,  2,  3'b000, 2'b10, 5,  2'b00, 0,  0, 2'b00, 2'b00);
    step("fwd_both",      0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b1100, 3'b000, 2'b10, 5,  5,  3'b000, 2'b10, 5,  2'b10, 5,  0, 2'b10, 2'b10);
    // Producer of r5, a gap, then a consumer: r5 only in MEM/WB.
    step("p5",            0, 4'b1100, 3'b000, 2'b10, 0, 0, 0,  0,  5,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b10, 8,  2'b10, 5,  0, 2'b00, 2'b00);
    step("p5_gap",        0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b1100, 3'b000, 2'b10, 0,  0,  3'b000, 2'b00, 0,  2'b10, 8,  0, 2'b00, 2'b00);
    step("c5",            0, 4'b1100, 3'b000, 2'b10, 0, 0, 5,  5,  9,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b10, 5,  2'b00, 0,  0, 2'b00, 2'b00);
    step("fwd_memwb",     0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b1100, 3'b000, 2'b10, 5,  5,  3'b000, 2'b00, 0,  2'b10, 5,  0, 2'b01, 2'b01);
    // Producer writing r0 followed by a reader of r0: never forwards.
    step("r0_producer",   0, 4'b1100, 3'b000, 2'b10, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b10, 9,  2'b00, 0,  0, 2'b00, 2'b00);
    step("r0_reader",     0, 4'b1100, 3'b000, 2'b10, 0, 0, 0,  0,  10, 4'b1100, 3'b000, 2'b10, 0,  0,  3'b000, 2'b00, 0,  2'b10, 9,  0, 2'b00, 2'b00);
    step("r0_exmem",      0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b1100, 3'b000, 2'b10, 0,  0,  3'b000, 2'b10, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    step("r0_memwb",      0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b10, 10, 2'b10, 0,  0, 2'b00, 2'b00);
    // LW to r0 with a reader of r0: no stall.
    step("lw_r0",         0, 4'b0001, 3'b010, 2'b11, 0, 0, 1,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b10, 10, 0, 2'b00, 2'b00);
    step("lw_r0_nostall", 0, 4'b1100, 3'b000, 2'b10, 0, 0, 0,  0,  11, 4'b0001, 3'b010, 2'b11, 1,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    step("lw_r0_after",   0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b1100, 3'b000, 2'b10, 0,  0,  3'b010, 2'b11, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    // Load-use hazard coinciding with ID_flush and EX_flush.
    step("lw6",           0, 4'b0001, 3'b010, 2'b11, 0, 0, 2,  6,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b10, 11, 2'b11, 0,  0, 2'b00, 2'b00);
    step("flush_hazard",  0, 4'b1100, 3'b000, 2'b10, 1, 1, 3,  6,  12, 4'b0001, 3'b010, 2'b11, 2,  6,  3'b000, 2'b00, 0,  2'b10, 11, 0, 2'b00, 2'b00);
    step("flushed",       0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    // Fill every stage with nonzero bundles, then reset mid-cycle.
    step("fill_x1",       0, 4'b1111, 3'b111, 2'b11, 0, 0, 7,  8,  9,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
`ifdef CTRL_PIPE_PERF_EN
    check("perf.stall_cnt", 32'(stall_cnt), 32'd1);
    check("perf.flush_cnt", 32'(flush_cnt), 32'd1);
`endif
    step("fill_x2",       0, 4'b1010, 3'b101, 2'b01, 0, 0, 10, 11, 12, 4'b1111, 3'b111, 2'b11, 7,  8,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    step("fill_x3",       0, 4'b0110, 3'b000, 2'b10, 0, 0, 1,  2,  3,  4'b1010, 3'b101, 2'b01, 10, 11, 3'b111, 2'b11, 9,  2'b00, 0,  0, 2'b00, 2'b00);
    step("async_reset",   1, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
    step("after_reset",   0, 4'b0000, 3'b000, 2'b00, 0, 0, 0,  0,  0,  4'b0000, 3'b000, 2'b00, 0,  0,  3'b000, 2'b00, 0,  2'b00, 0,  0, 2'b00, 2'b00);
`ifdef CTRL_PIPE_PERF_EN
    check("perf.stall_cnt_rst", 32'(stall_cnt), 32'd0);
    check("perf.flush_cnt_rst", 32'(flush_cnt), 32'd0);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Consumes the per-instruction control bundles (EX/M/WB) and flushes produced by the ID-stage controller.
- Carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers together with register addresses.
- Detects load-use hazards, producing a one-cycle stall and a bubble.
- Generates ALU operand forwarding selects for the EX stage.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- PERF_W, 16, width of the stall/flush counters (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-high.
- EX  in  4  from controller: {RegDst, ALUOp[1:0], ALUSrc}.
- M  in  3  from controller: {Branch, MemRead, MemWrite}.
- WB  in  2  from controller: {RegWrite, MemtoReg}.
- ID_flush  in  1  clear the ID/EX control register.
- EX_flush  in  1  clear the EX/MEM control register.
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  register fields of the instruction in ID.
- idex_EX  out  4  ID/EX-stage EX controls.
- idex_M  out  3  ID/EX-stage M controls.
- idex_WB  out  2  ID/EX-stage WB controls.
- idex_rs, idex_rt  out  REG_ADDR_W  source registers in EX.
- exmem_M  out  3  EX/MEM-stage M controls.
- exmem_WB  out  2  EX/MEM-stage WB controls.
- exmem_dst  out  REG_ADDR_W  EX/MEM destination register.
- memwb_WB  out  2  MEM/WB-stage WB controls.
- memwb_dst  out  REG_ADDR_W  MEM/WB destination register.
- stall  out  1  hold PC and IF/ID this cycle.
- ForwardA, ForwardB  out  2  EX operand selects: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.

Behaviour:
- Reset: every stage register (controls and register addresses) clears to 0 asynchronously. stall=0, ForwardA=ForwardB=00.
- Stage advance on each posedge clk:
  - ID/EX <= {EX, M, WB, id_rs, id_rt, id_rd}.
  - EX/MEM <= {idex_M, idex_WB, dst}, where dst = idex_EX[3] ? idex_rd : idex_rt.
  - MEM/WB <= {exmem_WB, exmem_dst}.
- Latency: a bundle reaches idex_* 1 cycle after it is presented, exmem_* after 2 cycles, memwb_* after 3 cycles.
- Load-use hazard (combinational): stall = idex_M[1] && idex_rt != 0 && (idex_rt == id_rs || idex_rt == id_rt).
- When stall=1: the ID/EX control fields load 0 (bubble). The ID/EX address fields still load. EX/MEM and MEM/WB advance normally.
- stall self-clears the next cycle, because the bubble has MemRead=0. Maximum stall length is 1 cycle per load.
- Flush and bubble priority: rst > ID_flush > stall bubble > normal load.
  - ID_flush zeroes all ID/EX fields.
  - EX_flush zeroes EX/MEM controls and dst. ID_flush and EX_flush are independent and may assert together.
- stall is not asserted while ID_flush=1.
- Forwarding (combinational, per operand X in {rs, rt}):
  - 10 if exmem_WB[1] && exmem_dst != 0 && exmem_dst == idex_X.
  - else 01 if memwb_WB[1] && memwb_dst != 0 && memwb_dst == idex_X.
  - else 00.
  - EX/MEM wins when both stages match the same register.
- Register 0 never triggers a stall or a forward.
- Controls pass through unmodified (no re-decoding). Undefined bits propagate as given.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- With it: adds outputs stall_cnt and flush_cnt, each PERF_W wide.
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with ID_flush|EX_flush.
  - Both saturate at all-ones and clear on rst.
- Without it: the ports and counters do not exist, with no other behavioural difference.

Decomposition:
- def.v gains the control-bundle bit-position constants: RegDst=3, ALUOp=2:1, ALUSrc=0, Branch=2, MemRead=1, MemWrite=0, RegWrite=1, MemtoReg=0. It also gains the forward-select encodings FWD_RF, FWD_EXMEM, FWD_MEMWB.
- One sub-module, forwarding_unit: purely combinational, instantiated once, computes ForwardA/ForwardB.
- Hazard detection and stage registers stay in ctrl_pipeline.

Test Plan:
- rst asserted mid-stream with nonzero bundles in all stages -> all outputs 0 immediately, before the next clk edge; stall=0.
- R-type EX=1100, M=000, WB=10, id_rd=3, id_rt=2, then NOPs -> exmem_dst=3 at cycle 2, memwb_WB=10 and memwb_dst=3 at cycle 3.
- LW EX=0001, M=010, WB=11, rt=4, followed by an instruction with id_rs=4 -> stall=1 for exactly one cycle, and idex_EX/M/WB=0 the cycle after.
- Back-to-back R-types writing r5, then a consumer with rs=rt=5 -> ForwardA=ForwardB=10. The same instruction while r5 is in both EX/MEM and MEM/WB -> 10. With r5 only in MEM/WB -> 01.
- Producer writing r0 -> ForwardA/B stay 00. LW with rt=0 -> no stall.
- ID_flush and EX_flush asserted the same cycle as a load-use hazard -> ID/EX and EX/MEM clear and stall=0. With CTRL_PIPE_PERF_EN: flush_cnt increments by 1 and stall_cnt is unchanged.
